// File: rtl/burst_framer_if.sv
// Sample input and framed output bus of burst_framer.
// The master modport is the framer itself; slave is the surrounding source/sink.
interface burst_framer_if #(
  parameter int WIDTH = 17
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_sop;
  logic             dout_eop;
  logic [7:0]       drop_count;

  modport master (
    input  din, din_valid, dout_ready,
    output dout, dout_valid, dout_sop, dout_eop, drop_count
  );

  modport slave (
    output din, din_valid, dout_ready,
    input  dout, dout_valid, dout_sop, dout_eop, drop_count
  );
endinterface

// File: rtl/burst_framer.sv
// Buffers the product stream in a FIFO and emits header/payload/checksum frames
// once a full burst is resident, with valid/ready backpressure on the output.
module burst_framer #(
  parameter int WIDTH      = 17,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int IDLE_GAP   = 2
) (
  input logic            clk,
  input logic            rst,
  burst_framer_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BURST_C   = CW'(BURST_LEN);
  localparam logic [7:0]    BL8       = 8'(BURST_LEN);
  localparam logic [7:0]    BEAT_LAST = 8'(BURST_LEN - 1);
  localparam logic [3:0]    GAP_LAST  = (IDLE_GAP == 0) ? 4'd0 : 4'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_TRAILER,
    S_GAP
  } state_t;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [7:0]       drop_q;
  logic             full;
  logic             wr_en;
  logic             pop;

  state_t           state;
  logic [7:0]       seq;
  logic [7:0]       beat;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] csum;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             sop_q;
  logic             eop_q;

  // Full is judged on the registered count, so a same-cycle pop never rescues a write.
  always_comb begin
    full  = (count == DEPTH_C);
    wr_en = bus.din_valid && !full;
    pop   = (state == S_PAYLOAD) && bus.dout_ready;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
      if (bus.din_valid && full && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  // dout is preloaded with the next head word on each pop; every burst word is
  // already resident when the frame starts, so rd_ptr+1 is always valid data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      seq     <= '0;
      beat    <= '0;
      gap_cnt <= '0;
      csum    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count >= BURST_C) begin
            state   <= S_HEADER;
            dout_q  <= {1'b1, seq, BL8};
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
          end
        end
        S_HEADER: begin
          if (bus.dout_ready) begin
            state  <= S_PAYLOAD;
            dout_q <= mem[rd_ptr];
            sop_q  <= 1'b0;
            beat   <= '0;
          end
        end
        S_PAYLOAD: begin
          if (bus.dout_ready) begin
            csum <= csum + dout_q;
            if (beat == BEAT_LAST) begin
              state  <= S_TRAILER;
              dout_q <= csum + dout_q;
              eop_q  <= 1'b1;
            end else begin
              dout_q <= mem[rd_ptr + AW'(1)];
              beat   <= beat + 8'd1;
            end
          end
        end
        S_TRAILER: begin
          if (bus.dout_ready) begin
            seq     <= seq + 8'd1;
            csum    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            eop_q   <= 1'b0;
            gap_cnt <= '0;
            state   <= (IDLE_GAP == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_sop   = sop_q;
  assign bus.dout_eop   = eop_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_burst_framer.sv
// Directed self-checking bench for burst_framer: framing, backpressure,
// overflow drops, sequence wrap and mid-frame reset.
module tb_burst_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_framer_if #(.WIDTH(17)) bus ();

  burst_framer #(
    .WIDTH      (17),
    .BURST_LEN  (16),
    .FIFO_DEPTH (32),
    .IDLE_GAP   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int          cyc      = 0;
  int          rdy_mode = 0;

  logic [16:0] got_w [$];
  logic        got_sop [$];
  logic        got_eop [$];
  int          hdr_cyc [$];
  int          tr_cyc [$];

  logic        hold_pend = 1'b0;
  logic [16:0] hold_w;
  logic        hold_sop;
  logic        hold_eop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy_now();
    case (rdy_mode)
      0:       return 1'b1;
      1:       return cyc[0];
      default: return 1'b0;
    endcase
  endfunction

  // Inputs change on the falling edge; outputs seen here are those the next rising edge samples.
  task automatic tick(input logic r, input logic rdy, input logic dv, input logic [16:0] d);
    @(negedge clk);
    cyc++;
    if (hold_pend) begin
      check("hold_valid", {31'd0, bus.dout_valid}, 32'd1);
      check("hold_dout", {15'd0, bus.dout}, {15'd0, hold_w});
      check("hold_flags", {30'd0, bus.dout_sop, bus.dout_eop}, {30'd0, hold_sop, hold_eop});
      hold_pend = 1'b0;
    end
    rst            = r;
    bus.din        = d;
    bus.din_valid  = dv;
    bus.dout_ready = rdy;
    if (!r && bus.dout_valid) begin
      if (rdy) begin
        got_w.push_back(bus.dout);
        got_sop.push_back(bus.dout_sop);
        got_eop.push_back(bus.dout_eop);
        if (bus.dout_sop) hdr_cyc.push_back(cyc);
        if (bus.dout_eop) tr_cyc.push_back(cyc);
      end else begin
        hold_pend = 1'b1;
        hold_w    = bus.dout;
        hold_sop  = bus.dout_sop;
        hold_eop  = bus.dout_eop;
      end
    end
  endtask

  task automatic clear_q();
    got_w.delete();
    got_sop.delete();
    got_eop.delete();
    hdr_cyc.delete();
    tr_cyc.delete();
  endtask

  task automatic do_reset();
    hold_pend = 1'b0;
    for (int i = 0; i < 3; i++)
      tick(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 17'($urandom));
    tick(1'b0, 1'b0, 1'b0, '0);
    check("rst_dout", {15'd0, bus.dout}, 32'd0);
    check("rst_flags", {29'd0, bus.dout_valid, bus.dout_sop, bus.dout_eop}, 32'd0);
    check("rst_drop", {24'd0, bus.drop_count}, 32'd0);
    clear_q();
  endtask

  task automatic write_burst(input int base, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, rdy_now(), 1'b1, 17'(base + i));
  endtask

  task automatic run_until(input int n, input int budget);
    int b;
    b = 0;
    while (got_w.size() < n && b < budget) begin
      tick(1'b0, rdy_now(), 1'b0, '0);
      b++;
    end
    if (got_w.size() < n) check("timeout_words", got_w.size(), n);
  endtask

  task automatic check_frame(input string tag, input int off, input logic [16:0] hdr,
                             input int base, input logic [16:0] trl);
    int flag_err;
    flag_err = 0;
    check({tag, "_hdr"}, {15'd0, got_w[off]}, {15'd0, hdr});
    check({tag, "_sop"}, {31'd0, got_sop[off]}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      check({tag, "_pay"}, {15'd0, got_w[off+i]}, 32'(base + i - 1));
      if (got_sop[off+i] || got_eop[off+i]) flag_err++;
    end
    check({tag, "_payflags"}, flag_err, 0);
    check({tag, "_trl"}, {15'd0, got_w[off+17]}, {15'd0, trl});
    check({tag, "_eop"}, {31'd0, got_eop[off+17]}, 32'd1);
  endtask

  initial begin
    int s;
    int seen;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b0;

    // Single burst, ready held high
    do_reset();
    rdy_mode = 0;
    s = cyc + 1;
    write_burst(1, 16);
    run_until(18, 60);
    check_frame("single", 0, 17'h10010, 1, 17'h00088);
    check("start_latency", hdr_cyc[0] - s, 17);
    check("frame_span", tr_cyc[0] - hdr_cyc[0], 17);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      check("gap_valid", {31'd0, bus.dout_valid}, 32'd0);
    end

    // Backpressure: ready alternating
    do_reset();
    rdy_mode = 1;
    write_burst(1, 16);
    run_until(18, 100);
    check_frame("bp", 0, 17'h10010, 1, 17'h00088);

    // Overflow: 40 writes with ready low
    do_reset();
    rdy_mode = 2;
    write_burst(1, 40);
    tick(1'b0, 1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    check("ovf_drop", {24'd0, bus.drop_count}, 32'd8);
    check("ovf_hdr_wait", {14'd0, bus.dout_valid, bus.dout}, {14'd0, 1'b1, 17'h10010});
    rdy_mode = 0;
    run_until(36, 200);
    check_frame("ovf_f0", 0, 17'h10010, 1, 17'h00088);
    check_frame("ovf_f1", 18, 17'h10110, 17, 17'h00188);
    check("ovf_gap", hdr_cyc[1] - tr_cyc[0], 4);

    // Sequence wrap over 257 bursts
    do_reset();
    rdy_mode = 0;
    for (int b = 0; b < 257; b++) begin
      clear_q();
      write_burst(1, 16);
      run_until(18, 80);
      check("wrap_hdr", {15'd0, got_w[0]}, 32'h10010 + ((b & 255) << 8));
    end
    check("wrap_trl", {15'd0, got_w[17]}, 32'h88);

    // Reset after 5 payload transfers
    do_reset();
    rdy_mode = 0;
    write_burst(1, 16);
    run_until(6, 60);
    tick(1'b1, 1'b1, 1'b1, 17'h1ABCD);
    tick(1'b0, 1'b1, 1'b0, '0);
    check("midrst_valid", {31'd0, bus.dout_valid}, 32'd0);
    check("midrst_eop", {31'd0, bus.dout_eop}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      if (bus.dout_valid) seen++;
    end
    check("midrst_empty", seen, 0);
    clear_q();
    write_burst(1, 16);
    run_until(18, 60);
    check_frame("midrst_new", 0, 17'h10010, 1, 17'h00088);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/burst_framer.md
# burst_framer

Downstream stage of the round-robin TDM multiplier datapath. Consumes the 17-bit post-processed product stream at the system clock rate and buffers it in an internal FIFO. Once a full burst is queued, emits it as a framed packet: header word, `BURST_LEN` payload words, checksum trailer. The output uses a valid/ready handshake so downstream sinks (IO serializer, capture logic) can apply backpressure.

## Interface

- `WIDTH`, 17: sample/word width. Fixed at 17 by the header format.
- `BURST_LEN`, 16: payload words per frame, 1..255.
- `FIFO_DEPTH`, 32: FIFO entries, power of two, >= `BURST_LEN`.
- `IDLE_GAP`, 2: forced idle cycles after each trailer, 0..15.

- `clk` in 1: system clock (100 MHz domain). One clock.
- `rst` in 1: reset, synchronous and active-high.
- `din` in `WIDTH`: input sample.
- `din_valid` in 1: `din` is valid this cycle. No ready is returned; the source cannot be stalled.
- `dout` out `WIDTH`: frame word.
- `dout_valid` out 1: `dout` is valid.
- `dout_ready` in 1: sink accepts `dout`. A transfer occurs when `dout_valid && dout_ready`.
- `dout_sop` out 1: high with the header word.
- `dout_eop` out 1: high with the trailer word.
- `drop_count` out 8: count of input samples dropped because the FIFO was full. Saturates at 255.

## Operation

- **FIFO write:** on `din_valid`, write `din` if occupancy (registered count) < `FIFO_DEPTH`. Otherwise drop the sample and increment `drop_count` (saturating).
  - Full is evaluated on the registered count. A write while full is dropped even if a pop occurs in the same cycle.
- **Occupancy:** count_next = count + write - pop. Pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:**
  - IDLE: no valid. Go to HEADER when count >= `BURST_LEN`.
  - HEADER: `dout` = {1'b1, seq[7:0], `BURST_LEN`[7:0]}, `dout_sop`=1. Go to PAYLOAD on transfer.
  - PAYLOAD: `dout` = FIFO head. Each transfer pops one word and adds it to the checksum. Go to TRAILER after the `BURST_LEN`-th transfer.
  - TRAILER: `dout` = checksum, `dout_eop`=1. On transfer, seq increments (wraps 255 to 0) and checksum clears. Go to GAP, or to IDLE if `IDLE_GAP`=0.
  - GAP: valid low for `IDLE_GAP` cycles, then IDLE.
- **Checksum:** sum of the `BURST_LEN` payload words, modulo 2^`WIDTH` (carry discarded).
- **Handshake rules:**
  - While `dout_valid` && !`dout_ready`, `dout`, `dout_sop` and `dout_eop` hold stable. The FIFO head is not popped.
  - Once asserted within a frame, `dout_valid` stays high until the trailer transfers.
- **Payload availability:** no PAYLOAD-state stall is possible, because a frame starts only after `BURST_LEN` words are resident. Writes continue during a frame.
- **Reset (any state, including mid-frame):**
  - FSM returns to IDLE and the FIFO empties.
  - seq=0, checksum=0, `drop_count`=0.
  - `dout`=0, `dout_valid`=0, `dout_sop`=0, `dout_eop`=0.
  - A partial frame is abandoned without eop. `din_valid` is ignored while `rst` is high.

## Timing

- All outputs are registered, driven from state and the FIFO head. No combinational path from `dout_ready` to any output.
- **Start latency:** edge E makes count reach `BURST_LEN`. The FSM samples this at E+1, and `dout_valid`/`dout_sop` are high after E+1.
  - Example: words written on edges 0..15 give the header visible after edge 16.
- **Frame length:** with `dout_ready` held high, a frame occupies `BURST_LEN`+2 consecutive valid cycles (18 at default), then `IDLE_GAP` cycles with valid low, then one IDLE evaluation cycle.
- A write and a pop in the same cycle leave count unchanged (when not full).
- Checksum and seq updates take effect on the accepting edge.

## Test plan

- **Reset:** hold `rst` 3 cycles with random `din`/`din_valid` -> `dout`=0, `dout_valid`=`dout_sop`=`dout_eop`=0, `drop_count`=0.
- **Single burst:** write `din`=1..16 on consecutive cycles, `dout_ready`=1 ->
  - header 17'h10010 with sop;
  - payload 1..16;
  - trailer 136 (0x088) with eop;
  - 18 contiguous valid cycles, then 2 idle cycles.
- **Backpressure:** same stimulus, `dout_ready` alternating 0/1 -> identical word sequence, each word stable across its ready-low cycles, trailer 136.
- **Overflow:** `dout_ready`=0, write 1..40 -> 32 stored and `drop_count`=8. Release ready ->
  - frame with seq 0 (header 17'h10010), payload 1..16;
  - frame with seq 1 (header 17'h10110), payload 17..32.
- **Seq wrap:** send 257 full bursts -> headers carry seq 0..255, then 0 for the 257th.
- **Reset mid-frame:** assert `rst` after 5 payload transfers ->
  - `dout_valid`=0 after that edge, no eop emitted, FIFO empty.
  - New burst 1..16 after release -> header seq 0, trailer 136.
